// File: rtl/seletor_pkg.sv
// ---------------------------------------------------------------------------
// seletor_pkg
// Types and constants shared by the seletor_uc control unit and its bench.
//   estadoT        : FSM state codes. The codes are visible on db_estado.
//   saidasT        : bundle of the registered control outputs of seletor_uc.
//   HOLD_INTERVALOS_DEF : default number of interval-counter periods the
//                    servo holds at the end position.
//   HOLD_W         : width of the hold counter.
// ---------------------------------------------------------------------------
package seletor_pkg;

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        ESPERA   = 4'd1,
        ARMAZENA = 4'd2,
        AVALIA   = 4'd3,
        MOVE     = 4'd4,
        SEGURA   = 4'd5,
        RETORNA  = 4'd6,
        REJEITA  = 4'd7,
        ERRO     = 4'd8
    } estadoT;

    // Bit order matches the output port order of seletor_uc.
    typedef struct packed {
        logic enableReg;
        logic zeraUpdown;
        logic contaUpdown;
        logic zeraIntervalo;
        logic contaIntervalo;
        logic aceito;
        logic rejeitado;
        logic pronto;
    } saidasT;

    localparam int HOLD_INTERVALOS_DEF = 4;
    localparam int HOLD_W              = 3;

endpackage

// File: rtl/seletor_uc.sv
// ---------------------------------------------------------------------------
// seletor_uc
// Control unit of the weight selector. Digit bytes from the serial receiver
// are stored into the weight register; a '#' byte evaluates the current
// weight: in range -> the servo steps up to position 7, holds there for
// HOLD_INTERVALOS interval periods and returns; out of range -> rejected;
// maximum weight zero -> error flag.
//
// Optional feature (macro SELETOR_UC_DB_EN): adds output db_estado[3:0]
// carrying the current state code.
//
// Ports
//   clock, reset           : system clock, synchronous active-low reset
//   fimRecepcao, comando   : new byte pulse; byte is '#'
//   pesoMaxIgualZero       : stored maximum weight is zero
//   perteceAoIntervalo     : current weight inside [pesoMin, pesoMax]
//   fimContadorIntervalo   : interval counter terminal count
//   fimPosicao             : servo at position 7
//   enableReg              : load the received digit into the weight register
//   zeraUpdown/contaUpdown : clear / step the servo position counter
//   zeraIntervalo/contaIntervalo : clear / run the interval counter
//   aceito, rejeitado      : one-cycle result pulses
//   erro                   : level, last command issued with pesoMax = 0
//   pronto                 : idle, waiting for a byte
//
// All control outputs are registered: the actions decided while the FSM is
// in a state appear on the pins during the following clock cycle.
// ---------------------------------------------------------------------------
module seletor_uc
    import seletor_pkg::*;
#(
    parameter int HOLD_INTERVALOS = HOLD_INTERVALOS_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fimRecepcao,
    input  logic       comando,
    input  logic       pesoMaxIgualZero,
    input  logic       perteceAoIntervalo,
    input  logic       fimContadorIntervalo,
    input  logic       fimPosicao,
    output logic       enableReg,
    output logic       zeraUpdown,
    output logic       contaUpdown,
    output logic       zeraIntervalo,
    output logic       contaIntervalo,
    output logic       aceito,
    output logic       rejeitado,
    output logic       erro,
    output logic       pronto
`ifdef SELETOR_UC_DB_EN
    ,
    output logic [3:0] db_estado
`endif
);

    // Count value seen on the last interval of the hold.
    localparam logic [HOLD_W-1:0] HOLD_ULTIMO = HOLD_W'(HOLD_INTERVALOS - 1);

    estadoT            stateReg,   stateNext;
    logic [HOLD_W-1:0] holdCntReg, holdCntNext;
    logic              erroReg,    erroNext;
    saidasT            saidasReg,  saidasNext;

    // -----------------------------------------------------------------------
    // Next state, hold counter, error flag and output actions
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext   = stateReg;
        holdCntNext = holdCntReg;
        erroNext    = erroReg;
        saidasNext  = '0;

        // Any new byte acknowledges a previous error; the ERRO state below
        // overrides this so the flag is set on the cycle it is raised.
        if (fimRecepcao) begin
            erroNext = 1'b0;
        end

        case (stateReg)
            INICIAL: begin
                saidasNext.zeraUpdown    = 1'b1;
                saidasNext.zeraIntervalo = 1'b1;
                holdCntNext              = '0;
                stateNext                = ESPERA;
            end

            ESPERA: begin
                saidasNext.pronto = 1'b1;
                if (fimRecepcao) begin
                    stateNext = comando ? AVALIA : ARMAZENA;
                end
            end

            ARMAZENA: begin
                saidasNext.enableReg = 1'b1;
                stateNext            = ESPERA;
            end

            AVALIA: begin
                if (pesoMaxIgualZero) begin
                    stateNext = ERRO;
                end else if (perteceAoIntervalo) begin
                    stateNext = MOVE;
                end else begin
                    stateNext = REJEITA;
                end
            end

            MOVE: begin
                // Reaching the end position wins over a coincident interval
                // tick, so the servo never steps past position 7.
                if (fimPosicao) begin
                    saidasNext.zeraIntervalo = 1'b1;
                    stateNext                = SEGURA;
                end else begin
                    saidasNext.contaIntervalo = 1'b1;
                    saidasNext.contaUpdown    = fimContadorIntervalo;
                end
            end

            SEGURA: begin
                saidasNext.contaIntervalo = 1'b1;
                if (fimContadorIntervalo) begin
                    if (holdCntReg == HOLD_ULTIMO) begin
                        stateNext = RETORNA;
                    end else begin
                        holdCntNext = holdCntReg + HOLD_W'(1);
                    end
                end
            end

            RETORNA: begin
                saidasNext.zeraUpdown    = 1'b1;
                saidasNext.zeraIntervalo = 1'b1;
                saidasNext.aceito        = 1'b1;
                holdCntNext              = '0;
                stateNext                = ESPERA;
            end

            REJEITA: begin
                saidasNext.rejeitado  = 1'b1;
                saidasNext.zeraUpdown = 1'b1;
                stateNext             = ESPERA;
            end

            ERRO: begin
                erroNext  = 1'b1;
                stateNext = ESPERA;
            end

            default: begin
                stateNext = INICIAL;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            stateReg   <= INICIAL;
            holdCntReg <= '0;
            erroReg    <= 1'b0;
            saidasReg  <= '0;
        end else begin
            stateReg   <= stateNext;
            holdCntReg <= holdCntNext;
            erroReg    <= erroNext;
            saidasReg  <= saidasNext;
        end
    end

    assign enableReg      = saidasReg.enableReg;
    assign zeraUpdown     = saidasReg.zeraUpdown;
    assign contaUpdown    = saidasReg.contaUpdown;
    assign zeraIntervalo  = saidasReg.zeraIntervalo;
    assign contaIntervalo = saidasReg.contaIntervalo;
    assign aceito         = saidasReg.aceito;
    assign rejeitado      = saidasReg.rejeitado;
    assign pronto         = saidasReg.pronto;
    assign erro           = erroReg;

`ifdef SELETOR_UC_DB_EN
    assign db_estado = stateReg;
`endif

endmodule
